axi_reg_write_ctrl: RTL and testbench
=====================================

Name: axi_reg_write_ctrl

Overview:
- AXI4-Lite write-path controller for the register block.
- Accepts the AW and W channels independently, holds each in a one-deep buffer, and decodes the register index and byte offset.
- Produces a one-cycle per-byte write-enable pulse for the register file, then returns a B response.
- Generalises per-lane enable generation to any data width and register count, and adds the channel handshakes, buffering and error response.

Parameters:
- DATA_W, 32, data bus width in bits; one of 32 or 64. STRB_W = DATA_W/8, OFS_W = log2(STRB_W).
- ADDR_W, 8, AW address width in bits; must exceed OFS_W.
- NUM_REGS, 16, number of implemented registers. IDX_W = max(1, clog2(NUM_REGS)).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- s_awvalid  in  1  AW valid
- s_awready  out  1  AW ready
- s_awaddr  in  ADDR_W  byte address
- s_wvalid  in  1  W valid
- s_wready  out  1  W ready
- s_wdata  in  DATA_W  write data
- s_wstrb  in  STRB_W  write strobes
- s_bvalid  out  1  B valid
- s_bready  in  1  B ready
- s_bresp  out  2  B response
- reg_we  out  STRB_W  per-byte write enable, one-cycle pulse
- reg_idx  out  IDX_W  target register index
- reg_wdata  out  DATA_W  write data, not shifted; lane i carries s_wdata byte i

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - state = IDLE, aw_full = 0, w_full = 0.
  - s_bvalid = 0, s_bresp = 00, reg_we = 0, reg_idx = 0, reg_wdata = 0.
  - s_awready = s_wready = 1 from the first cycle after release.
- Buffers:
  - aw_full/addr capture on s_awvalid & s_awready.
  - w_full/data/strb capture on s_wvalid & s_wready.
  - s_awready = (state == IDLE) & ~aw_full; s_wready = (state == IDLE) & ~w_full. Both are combinational from registers only, never from the valid inputs.
  - AW and W may arrive in either order, with any gap, or in the same cycle.
- State machine states: IDLE, WRITE, RESP.
- IDLE -> WRITE: on the edge where both buffers are full after that cycle's captures.
  - Same-cycle AW and W capture in cycle N gives WRITE in cycle N+1.
- WRITE (exactly one cycle):
  - idx = addr[ADDR_W-1:OFS_W]; ofs = addr[OFS_W-1:0].
  - err = (idx >= NUM_REGS).
  - reg_we = err ? 0 : (strb & lane_mask(ofs)); lane_mask sets lanes ofs..STRB_W-1.
  - reg_idx = idx truncated to IDX_W; reg_wdata = buffered data.
  - Both buffers are cleared. Next state is RESP.
  - s_bresp is registered at this edge: 2'b10 (SLVERR) if err, else 2'b00 (OKAY).
- RESP:
  - s_bvalid = 1; s_bresp is held stable.
  - Leave to IDLE on s_bvalid & s_bready. s_bvalid is low in the following cycle.
- Outputs outside WRITE: reg_we = 0; reg_idx and reg_wdata hold their last values.
- Boundary conditions:
  - Strobe all-zero: transaction completes, reg_we = 0, OKAY.
  - ofs != 0 with strobes below ofs: those lanes are masked off, OKAY (no error).
  - No new AW/W is accepted from capture-complete until the B handshake completes, so at most one transaction is outstanding.
  - Reset in WRITE or RESP: transaction dropped, s_bvalid falls immediately, no reg_we pulse is issued after reset.
  - s_bready held high in IDLE: no effect.

Decomposition:
- Package axi_reg_pkg:
  - typedef axi_resp_t, with constants RESP_OKAY = 2'b00 and RESP_SLVERR = 2'b10.
  - typedef wr_state_t enum {IDLE, WRITE, RESP}.
  - Helper function for STRB_W/OFS_W derivation.
- Sub-module lane_mask_gen (parameter STRB_W):
  - Purely combinational.
  - Inputs: ofs, strb, en. Output: enables.
  - Instantiated once in the WRITE datapath.

Test Plan:
- Single write, DATA_W=32, NUM_REGS=16: AW 0x08 and W 0xDEADBEEF/strb 1111 in the same cycle -> next cycle reg_we=1111, reg_idx=2, reg_wdata=0xDEADBEEF; the cycle after, s_bvalid=1 and s_bresp=00.
- Unaligned: AW 0x0E, strb 1111 -> reg_we=1100, reg_idx=3, OKAY. Repeat with strb 0011 -> reg_we=0000, OKAY.
- Out-of-order arrival: W presented 3 cycles before AW 0x04 -> s_wready=0 after W capture, no reg_we until the cycle after AW capture, then reg_we=1111, reg_idx=1.
- Error: AW 0x40 (idx 16), strb 1111 -> reg_we=0000 throughout, s_bresp=10. Repeat with DATA_W=64, AW 0x80 -> idx 16, same result.
- Backpressure: hold s_bready=0 for 5 cycles with a new AW/W pending -> s_bvalid=1 and s_bresp stable, s_awready=s_wready=0, new pair captured only after the B handshake.
- Reset mid-RESP: assert rst while s_bvalid=1 -> s_bvalid=0 in the same cycle; after release s_awready=s_wready=1 and no spurious reg_we.

Source files
------------

// File: rtl/axi_reg_pkg.sv
// Shared types and width helpers for the AXI4-Lite register write path.
//   axi_resp_t  : 2-bit B-channel response code (OKAY / SLVERR)
//   wr_state_t  : write controller states (IDLE, WRITE, RESP)
//   strb_width  : number of byte lanes for a data width
//   ofs_width   : byte-offset bits within one data word
//   idx_width   : register-index bits for a register count (at least 1)
package axi_reg_pkg;

    typedef logic [1:0] axi_resp_t;

    localparam axi_resp_t RESP_OKAY   = 2'b00;
    localparam axi_resp_t RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        RESP  = 2'd2
    } wr_state_t;

    function automatic int strb_width(input int data_w);
        return data_w / 8;
    endfunction

    function automatic int ofs_width(input int data_w);
        return $clog2(data_w / 8);
    endfunction

    function automatic int idx_width(input int num_regs);
        return (num_regs > 1) ? $clog2(num_regs) : 1;
    endfunction

endpackage

// File: rtl/axi_reg_write_ctrl_lane_mask.sv
// Per-byte write-enable generator.
//   ofs     : byte offset of the access inside the data word
//   strb    : write strobes from the W channel
//   en      : qualifies the whole result (low -> no lane enabled)
//   enables : strobes restricted to lanes ofs .. STRB_W-1
module lane_mask_gen #(
    parameter  int STRB_W = 4,
    localparam int OFS_W  = $clog2(STRB_W)
) (
    input  logic [OFS_W-1:0]  ofs,
    input  logic [STRB_W-1:0] strb,
    input  logic              en,
    output logic [STRB_W-1:0] enables
);

    // Shifting an all-ones vector left by ofs clears exactly the lanes below ofs.
    logic [STRB_W-1:0] lane_mask;

    assign lane_mask = {STRB_W{1'b1}} << ofs;
    assign enables   = en ? (strb & lane_mask) : '0;

endmodule

// File: rtl/axi_reg_write_ctrl.sv
// AXI4-Lite write-path controller for a register block.
//   clk, rst               : clock (rising edge), asynchronous active-high reset
//   s_aw*                  : write-address channel, one-deep buffered
//   s_w*                   : write-data channel, one-deep buffered
//   s_b*                   : write-response channel (OKAY, or SLVERR for a bad index)
//   reg_we                 : per-byte write-enable, one-cycle pulse in WRITE
//   reg_idx, reg_wdata     : target register and unshifted data, held outside WRITE
// AW and W are accepted in any order; once both are held the write is issued,
// and no new AW/W is accepted until the B handshake completes.
module axi_reg_write_ctrl
    import axi_reg_pkg::*;
#(
    parameter  int DATA_W   = 32,
    parameter  int ADDR_W   = 8,
    parameter  int NUM_REGS = 16,
    localparam int STRB_W   = strb_width(DATA_W),
    localparam int OFS_W    = ofs_width(DATA_W),
    localparam int IDX_W    = idx_width(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_awvalid,
    output logic              s_awready,
    input  logic [ADDR_W-1:0] s_awaddr,
    input  logic              s_wvalid,
    output logic              s_wready,
    input  logic [DATA_W-1:0] s_wdata,
    input  logic [STRB_W-1:0] s_wstrb,
    output logic              s_bvalid,
    input  logic              s_bready,
    output logic [1:0]        s_bresp,
    output logic [STRB_W-1:0] reg_we,
    output logic [IDX_W-1:0]  reg_idx,
    output logic [DATA_W-1:0] reg_wdata
);

    // Full word-index width of the address, before truncation to IDX_W.
    localparam int                WIDX_W     = ADDR_W - OFS_W;
    localparam logic [WIDX_W:0]   NUM_REGS_X = (WIDX_W + 1)'(NUM_REGS);

    wr_state_t         state_q, state_d;
    logic              aw_full_q, aw_full_d;
    logic              w_full_q, w_full_d;
    axi_resp_t         bresp_q, bresp_d;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic [STRB_W-1:0] strb_q;
    logic [IDX_W-1:0]  idx_hold_q;
    logic [DATA_W-1:0] wdata_hold_q;

    logic              aw_fire, w_fire, in_write, err;
    logic [WIDX_W-1:0] word_idx;
    logic [OFS_W-1:0]  byte_ofs;

    // Readies depend on registered state only, never on the valid inputs.
    assign s_awready = (state_q == IDLE) & ~aw_full_q;
    assign s_wready  = (state_q == IDLE) & ~w_full_q;
    assign aw_fire   = s_awvalid & s_awready;
    assign w_fire    = s_wvalid & s_wready;

    assign in_write = (state_q == WRITE);
    assign word_idx = addr_q[ADDR_W-1:OFS_W];
    assign byte_ofs = addr_q[OFS_W-1:0];
    assign err      = ({1'b0, word_idx} >= NUM_REGS_X);

    lane_mask_gen #(
        .STRB_W (STRB_W)
    ) u_lane_mask (
        .ofs     (byte_ofs),
        .strb    (strb_q),
        .en      (in_write & ~err),
        .enables (reg_we)
    );

    // Present the live transaction during WRITE, otherwise the last one issued.
    assign reg_idx   = in_write ? word_idx[IDX_W-1:0] : idx_hold_q;
    assign reg_wdata = in_write ? data_q : wdata_hold_q;
    assign s_bvalid  = (state_q == RESP);
    assign s_bresp   = bresp_q;

    // NOTE: every variable gets its default before the case so no path leaves it unassigned, which would infer a latch.
    always_comb begin
        state_d   = state_q;
        aw_full_d = aw_full_q;
        w_full_d  = w_full_q;
        bresp_d   = bresp_q;
        unique case (state_q)
            IDLE: begin
                if (aw_fire) aw_full_d = 1'b1;
                if (w_fire)  w_full_d  = 1'b1;
                // Includes this cycle's captures, so a same-cycle pair goes straight to WRITE.
                if (aw_full_d && w_full_d) state_d = WRITE;
            end
            WRITE: begin
                aw_full_d = 1'b0;
                w_full_d  = 1'b0;
                bresp_d   = err ? RESP_SLVERR : RESP_OKAY;
                state_d   = RESP;
            end
            RESP: begin
                if (s_bready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            aw_full_q    <= 1'b0;
            w_full_q     <= 1'b0;
            bresp_q      <= RESP_OKAY;
            idx_hold_q   <= '0;
            wdata_hold_q <= '0;
        end else begin
            state_q   <= state_d;
            aw_full_q <= aw_full_d;
            w_full_q  <= w_full_d;
            bresp_q   <= bresp_d;
            if (in_write) begin
                idx_hold_q   <= word_idx[IDX_W-1:0];
                wdata_hold_q <= data_q;
            end
        end
    end

    // NOTE: payload buffers carry no reset; their contents are only consumed while the matching full flag is set.
    always_ff @(posedge clk) begin
        if (aw_fire) addr_q <= s_awaddr;
        if (w_fire) begin
            data_q <= s_wdata;
            strb_q <= s_wstrb;
        end
    end

endmodule

// File: tb/tb_axi_reg_write_ctrl.sv
module tb_axi_reg_write_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // 32-bit, 16-register instance
    logic        s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
    logic [7:0]  s_awaddr;
    logic [31:0] s_wdata, reg_wdata;
    logic [3:0]  s_wstrb, reg_we, reg_idx;
    logic [1:0]  s_bresp;

    // 64-bit, 16-register instance
    logic        w64_awvalid, w64_awready, w64_wvalid, w64_wready, w64_bvalid, w64_bready;
    logic [7:0]  w64_awaddr, w64_wstrb, w64_reg_we;
    logic [63:0] w64_wdata, w64_reg_wdata;
    logic [3:0]  w64_reg_idx;
    logic [1:0]  w64_bresp;

    axi_reg_write_ctrl #(.DATA_W(32), .ADDR_W(8), .NUM_REGS(16)) dut (
        .clk(clk), .rst(rst),
        .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
        .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
        .reg_we(reg_we), .reg_idx(reg_idx), .reg_wdata(reg_wdata)
    );

    axi_reg_write_ctrl #(.DATA_W(64), .ADDR_W(8), .NUM_REGS(16)) dut64 (
        .clk(clk), .rst(rst),
        .s_awvalid(w64_awvalid), .s_awready(w64_awready), .s_awaddr(w64_awaddr),
        .s_wvalid(w64_wvalid), .s_wready(w64_wready), .s_wdata(w64_wdata), .s_wstrb(w64_wstrb),
        .s_bvalid(w64_bvalid), .s_bready(w64_bready), .s_bresp(w64_bresp),
        .reg_we(w64_reg_we), .reg_idx(w64_reg_idx), .reg_wdata(w64_reg_wdata)
    );

    // Values offered on AW/W while a response is stalled; they must not be taken.
    logic        pend;
    logic [7:0]  pend_addr;
    logic [31:0] pend_data;
    logic [3:0]  pend_strb;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Transaction-level reference: address split by arithmetic, lanes enabled
    // when strobed and at or above the byte offset, nothing for a bad index.
    function automatic void model(input int addr, input int strb, input int strb_w, input int nregs,
                                  output logic [7:0] we, output int idx, output logic [1:0] resp);
        int ofs;
        idx  = addr / strb_w;
        ofs  = addr % strb_w;
        we   = '0;
        resp = (idx >= nregs) ? 2'b10 : 2'b00;
        if (idx < nregs)
            for (int l = 0; l < strb_w; l++)
                if (((strb >> l) & 1) != 0 && l >= ofs) we[l] = 1'b1;
    endfunction

    task automatic do_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int aw_dly, input int w_dly, input int b_dly, input string tag);
        logic [7:0] exp_we;
        int         exp_idx;
        logic [1:0] exp_resp;
        bit         aw_done, w_done, aw_fire, w_fire;
        int         cyc;
        aw_done = 0; w_done = 0; cyc = 0;
        model(int'(addr), int'(strb), 4, 16, exp_we, exp_idx, exp_resp);
        while (!(aw_done && w_done)) begin
            s_awvalid = !aw_done && (cyc >= aw_dly);
            s_awaddr  = addr;
            s_wvalid  = !w_done && (cyc >= w_dly);
            s_wdata   = data;
            s_wstrb   = strb;
            aw_fire   = s_awvalid && s_awready;
            w_fire    = s_wvalid && s_wready;
            step();
            cyc++;
            s_awvalid = 1'b0;
            s_wvalid  = 1'b0;
            if (aw_fire) aw_done = 1;
            if (w_fire)  w_done  = 1;
            if (!(aw_done && w_done)) begin
                check({tag, "/we_while_waiting"}, 64'(reg_we), 64'd0);
                if (w_done)  check({tag, "/wready_after_capture"}, 64'(s_wready), 64'd0);
                if (aw_done) check({tag, "/awready_after_capture"}, 64'(s_awready), 64'd0);
            end
            if (cyc > 20) begin
                checks++;
                errors++;
                $error("FAIL %s/capture_timeout: observed=no_capture expected=capture", tag);
                break;
            end
        end
        // WRITE cycle
        check({tag, "/reg_we"}, 64'(reg_we), 64'(exp_we));
        check({tag, "/reg_idx"}, 64'(reg_idx), 64'(exp_idx % 16));
        check({tag, "/reg_wdata"}, 64'(reg_wdata), 64'(data));
        check({tag, "/bvalid_in_write"}, 64'(s_bvalid), 64'd0);
        s_bready = 1'b0;
        step();
        // RESP
        check({tag, "/bvalid"}, 64'(s_bvalid), 64'd1);
        check({tag, "/bresp"}, 64'(s_bresp), 64'(exp_resp));
        check({tag, "/we_after_write"}, 64'(reg_we), 64'd0);
        if (pend) begin
            s_awvalid = 1'b1; s_awaddr = pend_addr;
            s_wvalid  = 1'b1; s_wdata  = pend_data; s_wstrb = pend_strb;
        end
        for (int k = 0; k < b_dly; k++) begin
            step();
            check({tag, "/bvalid_stall"}, 64'(s_bvalid), 64'd1);
            check({tag, "/bresp_stable"}, 64'(s_bresp), 64'(exp_resp));
            check({tag, "/ready_stall"}, 64'({s_awready, s_wready}), 64'd0);
            check({tag, "/idx_hold"}, 64'(reg_idx), 64'(exp_idx % 16));
            check({tag, "/wdata_hold"}, 64'(reg_wdata), 64'(data));
            check({tag, "/we_stall"}, 64'(reg_we), 64'd0);
        end
        s_bready = 1'b1;
        step();
        s_bready  = 1'b0;
        s_awvalid = 1'b0;
        s_wvalid  = 1'b0;
        check({tag, "/bvalid_after_b"}, 64'(s_bvalid), 64'd0);
        check({tag, "/ready_after_b"}, 64'({s_awready, s_wready}), 64'd3);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "simulation watchdog expired");
    end

    initial begin
        logic [7:0]  r_addr;
        logic [31:0] r_data;
        logic [3:0]  r_strb;
        logic [7:0]  e_we;
        int          e_idx;
        logic [1:0]  e_resp;
        logic [7:0]  a64 [2];
        logic [63:0] d64;

        rst = 1'b1;
        pend = 1'b0;
        pend_addr = '0; pend_data = '0; pend_strb = '0;
        s_awvalid = 0; s_awaddr = 0; s_wvalid = 0; s_wdata = 0; s_wstrb = 0; s_bready = 0;
        w64_awvalid = 0; w64_awaddr = 0; w64_wvalid = 0; w64_wdata = 0; w64_wstrb = 0; w64_bready = 0;

        repeat (2) @(posedge clk);
        #1;
        check("reset/bvalid", 64'(s_bvalid), 64'd0);
        check("reset/bresp", 64'(s_bresp), 64'd0);
        check("reset/reg_we", 64'(reg_we), 64'd0);
        check("reset/reg_idx", 64'(reg_idx), 64'd0);
        check("reset/reg_wdata", 64'(reg_wdata), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        step();
        check("post_reset/ready", 64'({s_awready, s_wready}), 64'd3);

        do_write(8'h08, 32'hDEADBEEF, 4'b1111, 0, 0, 0, "single");
        do_write(8'h0E, 32'h11223344, 4'b1111, 0, 0, 1, "unaligned");
        do_write(8'h0E, 32'h55667788, 4'b0011, 0, 0, 0, "unaligned_low_strb");
        do_write(8'h04, 32'hCAFEF00D, 4'b1111, 3, 0, 0, "w_before_aw");
        do_write(8'h20, 32'h0BADC0DE, 4'b0101, 0, 2, 0, "aw_before_w");
        do_write(8'h30, 32'h01020304, 4'b0000, 0, 0, 0, "zero_strb");
        do_write(8'h40, 32'hFFFFFFFF, 4'b1111, 0, 0, 0, "error_idx16");

        pend = 1'b1; pend_addr = 8'h1C; pend_data = 32'hA5A5A5A5; pend_strb = 4'b1010;
        do_write(8'h10, 32'h12345678, 4'b1111, 0, 0, 5, "backpressure");
        pend = 1'b0;
        do_write(pend_addr, pend_data, pend_strb, 0, 0, 0, "after_backpressure");

        s_bready = 1'b1;
        repeat (3) begin
            step();
            check("bready_idle/bvalid", 64'(s_bvalid), 64'd0);
            check("bready_idle/ready", 64'({s_awready, s_wready}), 64'd3);
        end
        s_bready = 1'b0;

        for (int t = 0; t < 20; t++) begin
            r_addr = 8'($urandom_range(0, 8'h4F));
            r_data = $urandom;
            r_strb = 4'($urandom_range(0, 15));
            do_write(r_addr, r_data, r_strb, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                     int'($urandom_range(0, 3)), $sformatf("rand%0d", t));
        end

        a64[0] = 8'h80;
        a64[1] = 8'h0B;
        for (int t = 0; t < 2; t++) begin
            d64 = {$urandom, $urandom};
            model(int'(a64[t]), 8'hFF, 8, 16, e_we, e_idx, e_resp);
            w64_awvalid = 1'b1; w64_awaddr = a64[t];
            w64_wvalid  = 1'b1; w64_wdata  = d64; w64_wstrb = 8'hFF;
            check($sformatf("w64_%0d/ready", t), 64'({w64_awready, w64_wready}), 64'd3);
            step();
            w64_awvalid = 1'b0; w64_wvalid = 1'b0;
            check($sformatf("w64_%0d/reg_we", t), 64'(w64_reg_we), 64'(e_we));
            check($sformatf("w64_%0d/reg_idx", t), 64'(w64_reg_idx), 64'(e_idx % 16));
            check($sformatf("w64_%0d/reg_wdata", t), w64_reg_wdata, d64);
            step();
            check($sformatf("w64_%0d/bvalid", t), 64'(w64_bvalid), 64'd1);
            check($sformatf("w64_%0d/bresp", t), 64'(w64_bresp), 64'(e_resp));
            w64_bready = 1'b1;
            step();
            w64_bready = 1'b0;
            check($sformatf("w64_%0d/bvalid_after_b", t), 64'(w64_bvalid), 64'd0);
        end

        // Reset while the response is pending
        s_awvalid = 1'b1; s_awaddr = 8'h10; s_wvalid = 1'b1; s_wdata = 32'h77777777; s_wstrb = 4'b1111;
        step();
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        step();
        check("rst_resp/bvalid_before", 64'(s_bvalid), 64'd1);
        #2 rst = 1'b1;
        #1;
        check("rst_resp/bvalid_falls", 64'(s_bvalid), 64'd0);
        check("rst_resp/reg_idx", 64'(reg_idx), 64'd0);
        check("rst_resp/reg_wdata", 64'(reg_wdata), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        step();
        check("rst_resp/ready", 64'({s_awready, s_wready}), 64'd3);

        // Reset while the write pulse is being driven
        s_awvalid = 1'b1; s_awaddr = 8'h14; s_wvalid = 1'b1; s_wdata = 32'h88888888; s_wstrb = 4'b1111;
        step();
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        check("rst_write/we_before", 64'(reg_we), 64'hF);
        #2 rst = 1'b1;
        #1;
        check("rst_write/we_falls", 64'(reg_we), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
            step();
            check("rst_write/no_spurious_we", 64'(reg_we), 64'd0);
            check("rst_write/no_bvalid", 64'(s_bvalid), 64'd0);
            check("rst_write/ready", 64'({s_awready, s_wready}), 64'd3);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
